uart_tx_queue: RTL and testbench
================================

// Module: uart_tx_queue
// PURPOSE
//  Byte queue and pacing sequencer that sits directly upstream of the UART transmitter.
//  Producers (keyboard echo, arm telemetry) push bytes with a one-cycle write strobe.
//  The block buffers them in a FIFO and presents them one at a time on the transmitter's
//  transmit/data inputs. The transmitter has no busy output, so pacing is done by a
//  local frame timer.
// PARAMETERS
//  DEPTH          16     FIFO entries; power of 2, >= 2
//  CLKS_PER_BIT   10416  clk cycles per UART bit (100 MHz / 9600 baud)
//  FRAME_BITS     11     bit periods per frame slot: start + 8 data + stop + 1 guard
// PORTS
//  clk        in   1               system clock; all logic on rising edge
//  reset      in   1               synchronous, active-low reset
//  wr_en      in   1               push wr_data this cycle
//  wr_data    in   8               byte to queue
//  full       out  1               count == DEPTH
//  empty      out  1               count == 0
//  count      out  $clog2(DEPTH)+1 bytes currently queued (excludes the byte being sent)
//  overflow   out  1               1-cycle pulse: a write was dropped
//  tx_start   out  1               drives transmitter .transmit
//  tx_data    out  8               drives transmitter .data
// BEHAVIOUR
//  Reset (reset==0 at an edge): tx_start=0, tx_data=8'h00, count=0, empty=1, full=0,
//   overflow=0, pointers=0, frame counter=0, state=IDLE. Mid-frame reset aborts the
//   frame. The aborted byte and all queued bytes are discarded and never resent.
//  FRAME_CLKS = CLKS_PER_BIT*FRAME_BITS. Counter width is $clog2(FRAME_CLKS).
//  FSM:
//   IDLE: tx_start=0. If !empty: pop the head into tx_data, clear the counter, go to SEND.
//   SEND: tx_start=1 for exactly CLKS_PER_BIT cycles (counter 0..CLKS_PER_BIT-1),
//    then go to GAP.
//   GAP: tx_start=0. Count up to FRAME_CLKS-1, then go to IDLE.
//  tx_data is registered at the pop. It holds stable through SEND and GAP, and after
//   return to IDLE until the next pop.
//  Latency: a write into an empty queue while in IDLE makes count=1 after edge k.
//   Pop occurs at edge k+1, so tx_start=1 and tx_data are valid after edge k+1.
//  Back-to-back: each frame occupies FRAME_CLKS cycles plus one IDLE cycle.
//   Frame start period = FRAME_CLKS+1. At least one tx_start=0 cycle separates frames.
//  Write acceptance: a write is accepted iff count<DEPTH, or a pop occurs in the same
//   cycle. Write and pop in the same cycle leave count unchanged.
//  A write that is not accepted is dropped, the FIFO is unchanged, and overflow=1 for
//   the following cycle only.
//  Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is a separate
//   register; full and empty are decoded from count.
//  wr_en while reset==0 is ignored (no overflow pulse).
//  Bytes are transmitted in write order. No reordering and no duplication.
// STRUCTURE
//  uart_pkg (shared): typedef enum logic [1:0] {IDLE, SEND, GAP} uart_txq_state_t;
//   constants CLKS_PER_BIT_9600 = 10416 and UART_FRAME_BITS = 11.
//   The transmitter instance uses the same constants.
//  Sub-module sync_fifo #(WIDTH=8, DEPTH) holds storage, pointers, count and flags,
//   with push/pop/accept ports. uart_tx_queue contains the FSM, frame counter and
//   tx_data register.
// TESTING  (bench params: DEPTH=4, CLKS_PER_BIT=4, FRAME_BITS=11 -> FRAME_CLKS=44)
//  1 Hold reset=0 for 3 cycles with wr_en=1 -> tx_start=0, tx_data=00, empty=1,
//    count=0, overflow=0.
//  2 Write 0x69 once -> tx_start=1 for 4 cycles starting 1 cycle after count=1.
//    tx_data=0x69 held for 44 cycles; count returns to 0 at the pop.
//  3 Write 0x41,0x42,0x43 on consecutive cycles -> three tx_start pulses 45 cycles
//    apart, with data in order 41,42,43; empty=1 after the third pop.
//  4 While the first frame is sending, write 5 bytes -> first 4 accepted, full=1.
//    5th dropped; overflow=1 for exactly 1 cycle; dropped byte is never transmitted.
//  5 With full=1, write 0x55 on the IDLE pop cycle -> accepted, count stays 4.
//    0x55 is transmitted last.
//  6 Assert reset=0 for 1 cycle mid-SEND with 2 bytes queued -> next edge gives
//    tx_start=0, count=0, empty=1. No further tx_start after release until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module : uart_pkg
//  Shared UART timing constants and transmit-queue sequencer state encoding.
//  Rev    : 1.0
// ============================================================================
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } uart_txq_state_t;

   localparam int CLKS_PER_BIT_9600 = 10416;
   localparam int UART_FRAME_BITS   = 11;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module : sync_fifo
//  Single-clock FIFO with separate occupancy register; pushes are accepted
//  when not full or when a pop frees a slot in the same cycle.
//  Rev    : 1.0
// ============================================================================
module sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_wr_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_rd_data,
   output logic                   o_accept,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] c_depth = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic w_do_pop;
   logic w_accept;

   assign w_do_pop = i_pop && (r_count != '0);
   // A simultaneous pop frees the slot the push needs, so full does not block it.
   assign w_accept = i_push && ((r_count < c_depth) || w_do_pop);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_accept, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset && w_accept) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_accept  = w_accept;
   assign o_count   = r_count;
   assign o_full    = (r_count == c_depth);
   assign o_empty   = (r_count == '0);

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module : uart_tx_queue
//  Byte queue feeding the UART transmitter, paced by a local frame timer
//  because the transmitter exposes no busy indication.
//  Rev    : 1.0
// ============================================================================
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
   parameter int FRAME_BITS   = UART_FRAME_BITS
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [7:0]             wr_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   tx_start,
   output logic [7:0]             tx_data
);

   localparam int FRAME_CLKS = CLKS_PER_BIT * FRAME_BITS;
   localparam int CNT_W      = $clog2(FRAME_CLKS);
   localparam logic [CNT_W-1:0] c_send_last  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] c_frame_last = CNT_W'(FRAME_CLKS - 1);

   uart_txq_state_t  r_state;
   uart_txq_state_t  w_next_state;
   logic [CNT_W-1:0] r_frame_cnt;
   logic [7:0]       r_tx_data;
   logic             r_overflow;

   logic             w_pop;
   logic             w_tx_start;
   logic             w_accept;
   logic [7:0]       w_head;
   logic             w_empty;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_push    (wr_en),
      .i_wr_data (wr_data),
      .i_pop     (w_pop),
      .o_rd_data (w_head),
      .o_accept  (w_accept),
      .o_count   (count),
      .o_full    (full),
      .o_empty   (w_empty)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      w_tx_start   = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_next_state = SEND;
            end
         end
         SEND: begin
            w_tx_start = 1'b1;
            if (r_frame_cnt == c_send_last) begin
               w_next_state = GAP;
            end
         end
         GAP: begin
            if (r_frame_cnt == c_frame_last) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // One counter spans SEND and GAP so the frame slot length is exact.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_frame_cnt <= '0;
      end else if (w_pop) begin
         r_frame_cnt <= '0;
      end else if (r_state != IDLE) begin
         r_frame_cnt <= r_frame_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_tx_data  <= 8'h00;
         r_overflow <= 1'b0;
      end else begin
         if (w_pop) begin
            r_tx_data <= w_head;
         end
         r_overflow <= wr_en && !w_accept;
      end
   end

   assign empty    = w_empty;
   assign overflow = r_overflow;
   assign tx_start = w_tx_start;
   assign tx_data  = r_tx_data;

endmodule : uart_tx_queue
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module : tb_uart_tx_queue
//  Self-checking bench: queue/frame-slot reference model plus byte scoreboard.
//  Rev    : 1.0
// ============================================================================
module tb_uart_tx_queue;

   localparam int DEPTH      = 4;
   localparam int CPB        = 4;
   localparam int FB         = 11;
   localparam int FRAME_CLKS = CPB * FB;

   logic       clk     = 1'b0;
   logic       reset   = 1'b0;
   logic       wr_en   = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       full;
   logic       empty;
   logic [2:0] count;
   logic       overflow;
   logic       tx_start;
   logic [7:0] tx_data;

   always #5 clk = ~clk;

   uart_tx_queue #(
      .DEPTH        (DEPTH),
      .CLKS_PER_BIT (CPB),
      .FRAME_BITS   (FB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .tx_start (tx_start),
      .tx_data  (tx_data)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue contents, slot timer (cycles left in the current frame slot).
   logic [7:0] m_q[$];
   logic [7:0] exp_tx[$];
   int         m_busy    = 0;
   logic       m_ovf     = 1'b0;
   logic [7:0] m_last    = 8'h00;
   logic       m_started = 1'b0;

   always @(posedge clk) begin
      logic popped;
      popped    = 1'b0;
      m_ovf     = 1'b0;
      m_started = 1'b1;
      if (!reset) begin
         m_q.delete();
         m_busy = 0;
         m_last = 8'h00;
      end else begin
         if (m_busy > 0) begin
            m_busy--;
         end else if (m_q.size() > 0) begin
            popped = 1'b1;
            m_last = m_q.pop_front();
            exp_tx.push_back(m_last);
            m_busy = FRAME_CLKS;
         end
         if (wr_en) begin
            if (m_q.size() < DEPTH || popped) m_q.push_back(wr_data);
            else m_ovf = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         chk("count",    int'(count),    m_q.size());
         chk("empty",    int'(empty),    int'(m_q.size() == 0));
         chk("full",     int'(full),     int'(m_q.size() == DEPTH));
         chk("overflow", int'(overflow), int'(m_ovf));
         chk("tx_start", int'(tx_start), int'(m_busy > FRAME_CLKS - CPB));
         chk("tx_data",  int'(tx_data),  int'(m_last));
      end
   end

   // Scoreboard monitor: each new transmit pulse must carry the next expected byte.
   logic prev_start = 1'b0;
   always @(negedge clk) begin
      if (tx_start && !prev_start) begin
         if (exp_tx.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_byte: got unexpected 0x%0h expected no frame at %0t", tx_data, $time);
         end else begin
            chk("tx_byte", int'(tx_data), int'(exp_tx.pop_front()));
         end
      end
      prev_start = tx_start;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   initial begin
      logic [7:0] burst[3];
      bit         found;

      // Reset held with a write strobe asserted
      reset   = 1'b0;
      wr_en   = 1'b1;
      wr_data = 8'hEE;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      wr_en = 1'b0;

      write_byte(8'h69);
      idle(50);

      burst = '{8'h41, 8'h42, 8'h43};
      for (int i = 0; i < 3; i++) begin
         wr_en   = 1'b1;
         wr_data = burst[i];
         @(negedge clk);
      end
      wr_en = 1'b0;
      idle(3 * (FRAME_CLKS + 1) + 5);

      // Overfill while the first frame is in flight
      write_byte(8'hA0);
      idle(2);
      for (int i = 0; i < 5; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'($urandom_range(0, 255));
         @(negedge clk);
      end
      wr_en = 1'b0;

      // Push into a full queue on the exact pop cycle
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (m_busy == 0 && m_q.size() > 0) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("pop_cycle_reached", int'(found), 1);
      write_byte(8'h55);
      idle(5 * (FRAME_CLKS + 1) + 10);

      // Reset mid-SEND with two bytes still queued
      burst = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 3; i++) begin
         wr_en   = 1'b1;
         wr_data = burst[i];
         @(negedge clk);
      end
      wr_en = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      idle(100);

      // Randomized traffic, dense enough to overflow regularly
      repeat (600) begin
         wr_en   = ($urandom_range(0, 9) == 0);
         wr_data = 8'($urandom_range(0, 255));
         @(negedge clk);
      end
      wr_en = 1'b0;
      idle(6 * (FRAME_CLKS + 1));

      chk("scoreboard_drained", exp_tx.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_uart_tx_queue
`default_nettype wire
